// File: rtl/set_pkg.sv
// -----------------------------------------------------------------------------
// set_pkg
// Shared definitions for the SET job scheduler and the SET engine it feeds.
//   - state_t         : scheduler FSM encoding (IDLE, LAUNCH, WAIT, RESP)
//   - descriptor map  : bit offsets/widths of the candidate descriptor fields,
//                       so the scheduler and the engine agree on the layout
//   - DEF_*           : default widths and watchdog limit
// -----------------------------------------------------------------------------
package set_pkg;

    // Scheduler FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Candidate descriptor layout: centre x, centre y, radius, mode (LSB first).
    localparam int CFG_CX_W     = 8;
    localparam int CFG_CY_W     = 8;
    localparam int CFG_RAD_W    = 6;
    localparam int CFG_MODE_W   = 2;
    localparam int CFG_CX_OFF   = 0;
    localparam int CFG_CY_OFF   = CFG_CX_OFF + CFG_CX_W;
    localparam int CFG_RAD_OFF  = CFG_CY_OFF + CFG_CY_W;
    localparam int CFG_MODE_OFF = CFG_RAD_OFF + CFG_RAD_W;

    // Default widths: the descriptor width follows from the field map above.
    localparam int DEF_CFG_W   = CFG_MODE_OFF + CFG_MODE_W;
    localparam int DEF_RES_W   = 8;
    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/set_rr_arbiter.sv
// -----------------------------------------------------------------------------
// set_rr_arbiter
// Combinational round-robin pick among N_REQ request lines. The search starts
// one position above last_owner_i and wraps, so the previous owner is always
// considered last.
// Ports:
//   req_i        [N_REQ-1:0] request levels
//   last_owner_i [IDX_W-1:0] index of the most recently served requester
//   gnt_o        [N_REQ-1:0] one-hot pick (all zero when no request)
//   gnt_idx_o    [IDX_W-1:0] index of the pick (0 when no request)
//   any_o                    at least one request is pending
// -----------------------------------------------------------------------------
module set_rr_arbiter
    import set_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_owner_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_o
);

    // Walk the N_REQ candidates in priority order; the first one with a
    // pending request wins. The candidate index is wrapped with a subtract
    // rather than a modulo so non-power-of-two N_REQ works too.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cidx;
        logic             found;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = 0;
        cidx      = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = int'(last_owner_i) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cidx = cand[IDX_W-1:0];
            if (!found && req_i[cidx]) begin
                found         = 1'b1;
                gnt_o[cidx]   = 1'b1;
                gnt_idx_o     = cidx;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/set_job_scheduler.sv
// -----------------------------------------------------------------------------
// set_job_scheduler
// Shares a single SET engine between N_REQ requesters. Pending requests are
// arbitrated round-robin in IDLE, the winner's descriptor is latched and a
// start pulse issued, the engine result is awaited under a watchdog, and the
// count (or a timeout error) is returned to the owning requester.
// Ports:
//   clk_i, rst_i                clock (rising edge), async active-high reset
//   req_i        [N_REQ-1:0]    request levels
//   cfg_i        [N_REQ*CFG_W-1:0] packed descriptors, slice k = requester k
//   gnt_o        [N_REQ-1:0]    one-hot job owner, LAUNCH through RESP
//   rsp_valid_o  [N_REQ-1:0]    one-cycle response strobe to the owner
//   rsp_data_o   [RES_W-1:0]    result, valid with rsp_valid_o
//   rsp_err_o                   job timed out (with rsp_valid_o)
//   eng_start_o                 one-cycle engine launch pulse
//   eng_cfg_o    [CFG_W-1:0]    latched descriptor for the engine
//   eng_valid_i                 engine result strobe
//   eng_result_i [RES_W-1:0]    engine count
//   busy_o                      scheduler not in IDLE
// -----------------------------------------------------------------------------
module set_job_scheduler
    import set_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int CFG_W   = DEF_CFG_W,
    parameter int RES_W   = DEF_RES_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*CFG_W-1:0] cfg_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       rsp_valid_o,
    output logic [RES_W-1:0]       rsp_data_o,
    output logic                   rsp_err_o,
    output logic                   eng_start_o,
    output logic [CFG_W-1:0]       eng_cfg_o,
    input  logic                   eng_valid_i,
    input  logic [RES_W-1:0]       eng_result_i,
    output logic                   busy_o
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    state_t           state;
    logic [IDX_W-1:0] last_owner;
    logic [IDX_W-1:0] owner;
    logic [WD_W-1:0]  wd_cnt;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;

    logic [CFG_W-1:0] cfg_slice [N_REQ];

    // Unpack the flat descriptor bus so the winner can be selected by index.
    for (genvar k = 0; k < N_REQ; k++) begin : g_cfg
        assign cfg_slice[k] = cfg_i[k*CFG_W +: CFG_W];
    end

    set_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i        (req_i),
        .last_owner_i (last_owner),
        .gnt_o        (arb_gnt),
        .gnt_idx_o    (arb_idx),
        .any_o        (arb_any)
    );

    // Job FSM. All externally visible strobes are registered here; the start
    // and response strobes default low so each lasts exactly one cycle.
    // The watchdog counts WAIT cycles; an engine valid on the very cycle the
    // watchdog expires still wins because it is tested first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            last_owner  <= IDX_W'(N_REQ - 1);
            owner       <= '0;
            wd_cnt      <= '0;
            gnt_o       <= '0;
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
            eng_start_o <= 1'b0;
            eng_cfg_o   <= '0;
        end else begin
            eng_start_o <= 1'b0;
            rsp_valid_o <= '0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        owner       <= arb_idx;
                        gnt_o       <= arb_gnt;
                        eng_cfg_o   <= cfg_slice[arb_idx];
                        eng_start_o <= 1'b1;
                        state       <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    wd_cnt <= '0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (eng_valid_i) begin
                        rsp_valid_o <= gnt_o;
                        rsp_data_o  <= eng_result_i;
                        rsp_err_o   <= 1'b0;
                        state       <= ST_RESP;
                    end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        rsp_valid_o <= gnt_o;
                        rsp_data_o  <= '0;
                        rsp_err_o   <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    last_owner <= owner;
                    gnt_o      <= '0;
                    rsp_data_o <= '0;
                    rsp_err_o  <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_set_job_scheduler.sv
// -----------------------------------------------------------------------------
// tb_set_job_scheduler
// Self-checking bench for set_job_scheduler: a table of single-job vectors,
// hand-written reset/fairness sequences, and a randomized phase checked
// against a job-level reference model.
// -----------------------------------------------------------------------------
module tb_set_job_scheduler;

    localparam int N  = 4;
    localparam int CW = 24;
    localparam int RW = 8;
    localparam int TO = 64;

    logic            clk_i;
    logic            rst_i;
    logic [N-1:0]    req_i;
    logic [N*CW-1:0] cfg_i;
    logic [N-1:0]    gnt_o;
    logic [N-1:0]    rsp_valid_o;
    logic [RW-1:0]   rsp_data_o;
    logic            rsp_err_o;
    logic            eng_start_o;
    logic [CW-1:0]   eng_cfg_o;
    logic            eng_valid_i;
    logic [RW-1:0]   eng_result_i;
    logic            busy_o;

    int checks;
    int failures;

    set_job_scheduler #(
        .N_REQ   (N),
        .CFG_W   (CW),
        .RES_W   (RW),
        .TIMEOUT (TO)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .cfg_i        (cfg_i),
        .gnt_o        (gnt_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .eng_start_o  (eng_start_o),
        .eng_cfg_o    (eng_cfg_o),
        .eng_valid_i  (eng_valid_i),
        .eng_result_i (eng_result_i),
        .busy_o       (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // One job: requests, engine latency (0 = never, 1 = only during LAUNCH),
    // result, mid-job disturbance, and the expected owner/result/error.
    typedef struct {
        logic [N-1:0]  req;
        int            lat;
        logic [RW-1:0] res;
        bit            mid;
        int            owner;
        logic [RW-1:0] exp_data;
        bit            exp_err;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v = '0;
        v[k[1:0]] = 1'b1;
        return v;
    endfunction

    // Round-robin rule: first requester above the last owner, wrapping.
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int s = 1; s <= N; s++) begin
            int c;
            c = (last + s) % N;
            if (r[c[1:0]]) return c;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one job from IDLE, play the engine, and check start, response
    // timing/content and the return to IDLE.
    task automatic applyStimulus(input vec_t v);
        int            n;
        int            t;
        int            exp_t;
        bit            seen;
        logic [CW-1:0] lat_cfg;
        req_i = v.req;
        for (int k = 0; k < N; k++) cfg_i[k*CW +: CW] = CW'($urandom);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 6) begin
            @(negedge clk_i);
            n++;
            if (eng_start_o === 1'b1) seen = 1'b1;
        end
        checkOutput("start_latency", n, 1);
        if (!seen) begin
            eng_valid_i = 1'b0;
            return;
        end
        lat_cfg = cfg_i[v.owner*CW +: CW];
        checkOutput("start_gnt", gnt_o, onehot(v.owner));
        checkOutput("start_cfg", eng_cfg_o, lat_cfg);
        checkOutput("start_busy", busy_o, 1);
        exp_t = (v.lat >= 2 && v.lat <= TO + 1) ? v.lat : TO + 1;
        t = 0;
        while (t < TO + 10) begin
            eng_valid_i  = (v.lat >= 1 && t == v.lat - 1);
            eng_result_i = eng_valid_i ? v.res : RW'($urandom);
            if (v.mid && t == 3) begin
                req_i = '0;
                cfg_i = ~cfg_i;
            end
            @(negedge clk_i);
            t++;
            if (rsp_valid_o != '0) break;
        end
        eng_valid_i = 1'b0;
        checkOutput("rsp_time", t, exp_t);
        checkOutput("rsp_owner", rsp_valid_o, onehot(v.owner));
        checkOutput("rsp_data", rsp_data_o, v.exp_data);
        checkOutput("rsp_err", rsp_err_o, v.exp_err);
        checkOutput("rsp_gnt_held", gnt_o, onehot(v.owner));
        checkOutput("cfg_held", eng_cfg_o, lat_cfg);
        @(negedge clk_i);
        checkOutput("back_idle", {busy_o, rsp_valid_o, gnt_o, eng_start_o}, '0);
    endtask

    initial begin
        int            n;
        int            m_last;
        int            owner;
        int            c0;
        int            vcyc;
        int            rsp_cyc;
        int            lat;
        int            sel;
        bit            m_idle;
        bit            job_act;
        bit            rsp_last;
        bit            rsp_now;
        bit            was_idle;
        bit            exp_start;
        logic [RW-1:0] res;
        logic [RW-1:0] exp_d;
        bit            exp_e;
        logic [CW-1:0] m_cfg;
        vec_t          f;

        checks   = 0;
        failures = 0;

        // Vectors in order from reset (last owner = 3).
        vecs[0] = '{4'b0100, 18, 8'd23, 1'b0, 2, 8'd23, 1'b0};
        vecs[1] = '{4'b0110,  5, 8'h5A, 1'b0, 1, 8'h5A, 1'b0};
        vecs[2] = '{4'b0110,  2, 8'hFF, 1'b0, 2, 8'hFF, 1'b0};
        vecs[3] = '{4'b1001,  9, 8'h01, 1'b0, 3, 8'h01, 1'b0};
        vecs[4] = '{4'b1001, 65, 8'h77, 1'b0, 0, 8'h77, 1'b0};
        vecs[5] = '{4'b1000,  0, 8'h00, 1'b0, 3, 8'h00, 1'b1};
        vecs[6] = '{4'b0001, 64, 8'h42, 1'b0, 0, 8'h42, 1'b0};
        vecs[7] = '{4'b0011,  1, 8'h99, 1'b0, 1, 8'h00, 1'b1};
        vecs[8] = '{4'b1111,  3, 8'h10, 1'b1, 2, 8'h10, 1'b0};
        vecs[9] = '{4'b0010,  7, 8'h3C, 1'b1, 1, 8'h3C, 1'b0};

        rst_i        = 1'b1;
        req_i        = '0;
        cfg_i        = '0;
        eng_valid_i  = 1'b0;
        eng_result_i = '0;
        repeat (2) @(negedge clk_i);
        checkOutput("reset_outputs",
                    {gnt_o, rsp_valid_o, rsp_data_o, rsp_err_o, eng_start_o, busy_o, eng_cfg_o}, '0);
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("idle_after_reset", {busy_o, eng_start_o, gnt_o}, '0);

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);
        req_i = '0;

        // Reset during WAIT: outputs clear asynchronously, no response follows.
        $display("[TB] reset during WAIT");
        req_i = 4'b0100;
        n = 0;
        while (eng_start_o !== 1'b1 && n < 6) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("rst_seq_start", eng_start_o, 1);
        repeat (6) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        checkOutput("async_reset",
                    {gnt_o, rsp_valid_o, rsp_data_o, rsp_err_o, eng_start_o, busy_o, eng_cfg_o}, '0);
        req_i = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checkOutput("no_rsp_after_reset", {rsp_valid_o, busy_o}, '0);
        end

        // Fairness: all requesting, order 0,1,2,3,0,1,2,3.
        $display("[TB] fairness rounds");
        for (int k = 0; k < 8; k++) begin
            f.req      = 4'b1111;
            f.lat      = 17;
            f.res      = RW'(k * 11 + 3);
            f.mid      = 1'b0;
            f.owner    = k % N;
            f.exp_data = f.res;
            f.exp_err  = 1'b0;
            applyStimulus(f);
        end

        // Randomized traffic against the job-level model.
        $display("[TB] random phase");
        m_last   = 3;
        m_idle   = 1'b1;
        job_act  = 1'b0;
        rsp_last = 1'b0;
        vcyc     = -1;
        rsp_cyc  = -1;
        owner    = 0;
        c0       = 0;
        res      = '0;
        exp_d    = '0;
        exp_e    = 1'b0;
        m_cfg    = '0;
        req_i    = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (rsp_last && k == owner) begin
                    req_i[k] = 1'b0;
                end else if (!req_i[k] && $urandom_range(0, 5) == 0) begin
                    req_i[k] = 1'b1;
                    cfg_i[k*CW +: CW] = CW'($urandom);
                end else if (job_act && k == owner && $urandom_range(0, 7) == 0) begin
                    cfg_i[k*CW +: CW] = CW'($urandom);
                end else if (job_act && k == owner && $urandom_range(0, 39) == 0) begin
                    req_i[k] = 1'b0;
                end
            end
            if (c == vcyc) begin
                eng_valid_i  = 1'b1;
                eng_result_i = res;
            end else if ((m_idle || rsp_last) && $urandom_range(0, 3) == 0) begin
                eng_valid_i  = 1'b1;
                eng_result_i = RW'($urandom);
            end else begin
                eng_valid_i  = 1'b0;
                eng_result_i = RW'($urandom);
            end

            @(negedge clk_i);

            was_idle  = m_idle;
            exp_start = was_idle && (req_i != '0);
            checkOutput("rnd_start", eng_start_o, exp_start);
            if (exp_start) begin
                owner = rr_pick(req_i, m_last);
                m_cfg = cfg_i[owner*CW +: CW];
                checkOutput("rnd_gnt", gnt_o, onehot(owner));
                checkOutput("rnd_cfg", eng_cfg_o, m_cfg);
                job_act = 1'b1;
                m_idle  = 1'b0;
                c0      = c;
                sel     = $urandom_range(0, 19);
                case (sel)
                    0:       lat = 1;
                    1:       lat = TO;
                    2:       lat = TO + 1;
                    3:       lat = TO + 2;
                    4:       lat = 0;
                    default: lat = $urandom_range(2, 30);
                endcase
                res  = RW'($urandom);
                vcyc = (lat == 0) ? -1 : c0 + lat;
                if (lat >= 2 && lat <= TO + 1) begin
                    rsp_cyc = c0 + lat;
                    exp_d   = res;
                    exp_e   = 1'b0;
                end else begin
                    rsp_cyc = c0 + TO + 1;
                    exp_d   = '0;
                    exp_e   = 1'b1;
                end
            end else if (job_act) begin
                checkOutput("rnd_gnt_held", gnt_o, onehot(owner));
                checkOutput("rnd_cfg_held", eng_cfg_o, m_cfg);
            end else begin
                checkOutput("rnd_gnt_idle", gnt_o, 0);
            end
            if (rsp_last) m_idle = 1'b1;
            rsp_now = job_act && (c == rsp_cyc);
            if (rsp_now) begin
                checkOutput("rnd_rsp_owner", rsp_valid_o, onehot(owner));
                checkOutput("rnd_rsp_data", rsp_data_o, exp_d);
                checkOutput("rnd_rsp_err", rsp_err_o, exp_e);
                m_last  = owner;
                job_act = 1'b0;
            end else begin
                checkOutput("rnd_no_rsp", rsp_valid_o, 0);
            end
            rsp_last = rsp_now;
            checkOutput("rnd_busy", busy_o, !m_idle);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
